// File: rtl/uart_cmd_parser_pkg.sv
// uart_cmd_pkg: shared constants for the debugger UART command parser.
// Holds the parser state encoding, the default frame start marker and the
// debugger opcode values used by the debug core and its test benches.
package uart_cmd_pkg;

    // Parser state encoding. Kept as plain constants so existing tools and
    // waveform decoders that expect fixed numeric states keep working.
    localparam int STATE_W = 3;
    typedef logic [STATE_W-1:0] state_t;

    localparam state_t ST_HUNT    = 3'd0;
    localparam state_t ST_OPCODE  = 3'd1;
    localparam state_t ST_LEN     = 3'd2;
    localparam state_t ST_PAYLOAD = 3'd3;
    localparam state_t ST_CHECK   = 3'd4;
    localparam state_t ST_HOLD    = 3'd5;

    // Default frame start marker.
    localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

    // Debugger opcodes understood by the debug core.
    localparam logic [7:0] OP_READ  = 8'h01;
    localparam logic [7:0] OP_WRITE = 8'h02;
    localparam logic [7:0] OP_HALT  = 8'h03;
    localparam logic [7:0] OP_STEP  = 8'h04;

endpackage : uart_cmd_pkg

// File: rtl/uart_gap_timer.sv
// uart_gap_timer: idle-gap watchdog for the command parser.
// Counts enabled clocks since the last clear. The terminal pulse is asserted
// combinationally on the clock in which the TIMEOUT_CYCLES-th idle edge will
// occur, so the owner can register its reaction on that same edge. A clear in
// the terminal cycle suppresses the pulse, letting a late byte win.
module uart_gap_timer #(
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic clk_in,
    input  logic rst_n_in,
    input  logic clear,
    input  logic enable,
    output logic terminal
);

    localparam int             CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] count_q;

    assign terminal = enable && !clear && (count_q == LAST);

    // Idle counter: restarts on every clear, while disabled and after expiry.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            count_q <= '0;
        end else if (clear || !enable || terminal) begin
            count_q <= '0;
        end else begin
            count_q <= count_q + 1'b1;
        end
    end

endmodule : uart_gap_timer

// File: rtl/uart_cmd_parser.sv
// uart_cmd_parser: turns the debugger UART receiver's byte strobes into
// framed commands (SYNC, OPCODE, LEN, PAYLOAD[0..LEN-1], optional CHECK) and
// offers each validated command to the debug core over valid/ready.
// Malformed, stalled and overrun frames are dropped and flagged with
// single-cycle registered pulses.
// Build option: define UART_CMD_CHECKSUM_EN to require a trailing XOR byte
// over OPCODE, LEN and payload; without it the frame ends at the last
// payload byte and err_chk_out is tied low.
module uart_cmd_parser
    import uart_cmd_pkg::*;
#(
    parameter int         MAX_PAYLOAD    = 8,
    parameter int         TIMEOUT_CYCLES = 1_000_000,
    parameter logic [7:0] SYNC_BYTE      = DEFAULT_SYNC_BYTE,
    localparam int        LEN_W          = $clog2(MAX_PAYLOAD + 1)
) (
    input  logic                     clk_in,
    input  logic                     rst_n_in,
    input  logic                     byte_valid_in,
    input  logic [7:0]               byte_in,
    output logic                     cmd_valid_out,
    input  logic                     cmd_ready_in,
    output logic [7:0]               cmd_opcode_out,
    output logic [LEN_W-1:0]         cmd_len_out,
    output logic [MAX_PAYLOAD*8-1:0] cmd_payload_out,
    output logic                     err_len_out,
    output logic                     err_chk_out,
    output logic                     err_timeout_out,
    output logic                     overrun_out
);

    localparam logic [7:0] MAX_LEN_BYTE = 8'(MAX_PAYLOAD);

    // State entered once the last frame byte (LEN=0 or final payload byte)
    // has been taken: either the check byte or straight to the hold.
`ifdef UART_CMD_CHECKSUM_EN
    localparam state_t ST_FRAME_END = ST_CHECK;
`else
    localparam state_t ST_FRAME_END = ST_HOLD;
`endif

    state_t                   state_q;
    state_t                   state_d;
    logic [7:0]               opcode_q;
    logic [LEN_W-1:0]         len_q;
    logic [LEN_W-1:0]         idx_q;
    logic [MAX_PAYLOAD*8-1:0] payload_q;
    logic                     cmd_valid_q;
    logic                     err_len_q;
    logic                     err_timeout_q;
    logic                     overrun_q;

    logic                     len_err;
    logic                     overrun;
    logic                     handshake;
    logic                     sync_hit;
    logic                     last_payload;
    logic                     in_frame;
    logic                     gap_expired;

`ifdef UART_CMD_CHECKSUM_EN
    logic [7:0]               xor_q;
    logic                     chk_err;
    logic                     err_chk_q;
`endif

    assign handshake    = cmd_valid_q & cmd_ready_in;
    assign sync_hit     = byte_valid_in && (byte_in == SYNC_BYTE);
    // idx_q < len_q <= MAX_PAYLOAD whenever this is used, so no wrap.
    assign last_payload = ((idx_q + 1'b1) == len_q);
    // The gap timer only runs while a frame is partially received.
    assign in_frame     = state_q inside {ST_OPCODE, ST_LEN, ST_PAYLOAD, ST_CHECK};

    uart_gap_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_gap_timer (
        .clk_in   (clk_in),
        .rst_n_in (rst_n_in),
        .clear    (byte_valid_in),
        .enable   (in_frame),
        .terminal (gap_expired)
    );

    // Next-state and event decode for the frame parser.
    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path
        // through the case can leave one unassigned and infer a latch.
        state_d = state_q;
        len_err = 1'b0;
        overrun = 1'b0;
`ifdef UART_CMD_CHECKSUM_EN
        chk_err = 1'b0;
`endif
        case (state_q)
            ST_HUNT: begin
                if (sync_hit) begin
                    state_d = ST_OPCODE;
                end
            end
            ST_OPCODE: begin
                if (byte_valid_in) begin
                    state_d = ST_LEN;
                end
            end
            ST_LEN: begin
                if (byte_valid_in) begin
                    if (byte_in > MAX_LEN_BYTE) begin
                        len_err = 1'b1;
                        state_d = ST_HUNT;
                    end else if (byte_in == 8'h00) begin
                        state_d = ST_FRAME_END;
                    end else begin
                        state_d = ST_PAYLOAD;
                    end
                end
            end
            ST_PAYLOAD: begin
                if (byte_valid_in && last_payload) begin
                    state_d = ST_FRAME_END;
                end
            end
`ifdef UART_CMD_CHECKSUM_EN
            ST_CHECK: begin
                if (byte_valid_in) begin
                    if (byte_in == xor_q) begin
                        state_d = ST_HOLD;
                    end else begin
                        chk_err = 1'b1;
                        state_d = ST_HUNT;
                    end
                end
            end
`endif
            ST_HOLD: begin
                // Anything arriving while a command is held is lost,
                // including a SYNC on the handshake cycle itself.
                overrun = byte_valid_in;
                if (handshake) begin
                    state_d = ST_HUNT;
                end
            end
            default: begin
                state_d = ST_HUNT;
            end
        endcase
        // Expiry only fires in frame states on a cycle with no byte, so it
        // never competes with a byte-driven transition above.
        if (gap_expired) begin
            state_d = ST_HUNT;
        end
    end

    // Control registers: state, command valid and the error/overrun pulses.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q       <= ST_HUNT;
            cmd_valid_q   <= 1'b0;
            err_len_q     <= 1'b0;
            err_timeout_q <= 1'b0;
            overrun_q     <= 1'b0;
`ifdef UART_CMD_CHECKSUM_EN
            err_chk_q     <= 1'b0;
`endif
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register here samples the values from before this edge.
            state_q       <= state_d;
            cmd_valid_q   <= (state_d == ST_HOLD);
            err_len_q     <= len_err;
            err_timeout_q <= gap_expired;
            overrun_q     <= overrun;
`ifdef UART_CMD_CHECKSUM_EN
            err_chk_q     <= chk_err;
`endif
        end
    end

    // Frame datapath: opcode, length, payload slots, byte index and XOR.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            // NOTE: the payload is a flop array rather than a RAM, so it is
            // reset with everything else and never exposes stale data.
            opcode_q  <= '0;
            len_q     <= '0;
            idx_q     <= '0;
            payload_q <= '0;
`ifdef UART_CMD_CHECKSUM_EN
            xor_q     <= '0;
`endif
        end else if (byte_valid_in) begin
            case (state_q)
                ST_HUNT: begin
                    if (sync_hit) begin
                        idx_q     <= '0;
                        payload_q <= '0;
`ifdef UART_CMD_CHECKSUM_EN
                        xor_q     <= '0;
`endif
                    end
                end
                ST_OPCODE: begin
                    opcode_q <= byte_in;
`ifdef UART_CMD_CHECKSUM_EN
                    xor_q    <= xor_q ^ byte_in;
`endif
                end
                ST_LEN: begin
                    len_q <= LEN_W'(byte_in);
`ifdef UART_CMD_CHECKSUM_EN
                    xor_q <= xor_q ^ byte_in;
`endif
                end
                ST_PAYLOAD: begin
                    for (int i = 0; i < MAX_PAYLOAD; i++) begin
                        if (idx_q == LEN_W'(i)) begin
                            payload_q[i*8 +: 8] <= byte_in;
                        end
                    end
                    idx_q <= idx_q + 1'b1;
`ifdef UART_CMD_CHECKSUM_EN
                    xor_q <= xor_q ^ byte_in;
`endif
                end
                default: begin
                end
            endcase
        end
    end

    assign cmd_valid_out   = cmd_valid_q;
    assign cmd_opcode_out  = opcode_q;
    assign cmd_len_out     = len_q;
    assign cmd_payload_out = payload_q;
    assign err_len_out     = err_len_q;
    assign err_timeout_out = err_timeout_q;
    assign overrun_out     = overrun_q;
`ifdef UART_CMD_CHECKSUM_EN
    assign err_chk_out     = err_chk_q;
`else
    assign err_chk_out     = 1'b0;
`endif

endmodule : uart_cmd_parser
